// File: rtl/plic_claim_sequencer.sv
// APB4 master that services one PLIC target: claims the pending ID, hands it
// to a local handler, waits for the handler to finish, then writes the same ID
// back to the claim/complete register.
module plic_claim_sequencer #(
    parameter int                    PADDR_SIZE    = 32,
    parameter int                    PDATA_SIZE    = 32,
    parameter logic [PADDR_SIZE-1:0] BASE          = 32'h1000_0000,
    parameter int                    TARGET        = 0,
    parameter int                    SOURCES_BITS  = 4,
    parameter logic [PADDR_SIZE-1:0] CLAIM_OFFSET  = 32'h0020_0004,
    parameter logic [PADDR_SIZE-1:0] TARGET_STRIDE = 32'h0000_1000,
    parameter int                    TIMEOUT       = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      en,
    input  logic                      irq,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic [PADDR_SIZE-1:0]     PADDR,
    output logic                      PWRITE,
    output logic [PDATA_SIZE/8-1:0]   PSTRB,
    output logic [PDATA_SIZE-1:0]     PWDATA,
    input  logic [PDATA_SIZE-1:0]     PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR,
    output logic                      int_valid,
    output logic [SOURCES_BITS-1:0]   int_id,
    input  logic                      int_done,
    output logic [7:0]                spurious,
    output logic                      err
);

    // The claim and complete both target the same fixed register.
    localparam logic [PADDR_SIZE-1:0] CLAIM_ADDR =
        BASE + CLAIM_OFFSET + (PADDR_SIZE'(TARGET) * TARGET_STRIDE);

    // Wait counter must be able to hold TIMEOUT itself (TIMEOUT >= 2 assumed).
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_C_SETUP  = 3'd1,
        ST_C_ACCESS = 3'd2,
        ST_DISPATCH = 3'd3,
        ST_W_SETUP  = 3'd4,
        ST_W_ACCESS = 3'd5
    } state_t;

    state_t                    r_state;
    logic                      r_pending;
    logic [WAIT_W-1:0]         r_wait;
    logic                      r_psel;
    logic                      r_penable;
    logic                      r_pwrite;
    logic [PDATA_SIZE/8-1:0]   r_pstrb;
    logic [PDATA_SIZE-1:0]     r_pwdata;
    logic                      r_int_valid;
    logic [SOURCES_BITS-1:0]   r_int_id;
    logic [7:0]                r_spurious;
    logic                      r_err;

    logic [SOURCES_BITS-1:0]   w_claim_id;
    logic [PDATA_SIZE-1:0]     w_wdata;
    logic                      w_wait_expired;
    logic                      w_unused_rdata;

    // Only the low ID bits of the claim response carry meaning.
    assign w_claim_id     = PRDATA[SOURCES_BITS-1:0];
    assign w_unused_rdata = ^PRDATA[PDATA_SIZE-1:SOURCES_BITS];

    // This PREADY=0 cycle would bring the wait count up to TIMEOUT.
    assign w_wait_expired = (r_wait == WAIT_LAST);

    // Zero-extend the held ID onto the write data bus.
    for (genvar gi = 0; gi < PDATA_SIZE; gi++) begin : g_wdata
        if (gi < SOURCES_BITS) begin : g_id_bit
            assign w_wdata[gi] = r_int_id[gi];
        end else begin : g_zero_bit
            assign w_wdata[gi] = 1'b0;
        end
    end

    assign PADDR     = CLAIM_ADDR;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PSTRB     = r_pstrb;
    assign PWDATA    = r_pwdata;
    assign int_valid = r_int_valid;
    assign int_id    = r_int_id;
    assign spurious  = r_spurious;
    assign err       = r_err;

    // Claim/dispatch/complete sequencer; every bus and handler output is a register.
    // IDLE first latches en&irq into r_pending and launches the setup phase on
    // the following edge, so every transfer is separated by at least one idle
    // cycle and the PLIC has time to drop irq after a complete.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state     <= ST_IDLE;
            r_pending   <= 1'b0;
            r_wait      <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pstrb     <= '0;
            r_pwdata    <= '0;
            r_int_valid <= 1'b0;
            r_int_id    <= '0;
            r_spurious  <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_pending) begin
                        r_pending <= 1'b0;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_pwrite  <= 1'b0;
                        r_pstrb   <= '0;
                        r_pwdata  <= '0;
                        r_state   <= ST_C_SETUP;
                    end else begin
                        r_pending <= en & irq;
                    end
                end

                ST_C_SETUP: begin
                    r_penable <= 1'b1;
                    r_wait    <= '0;
                    r_state   <= ST_C_ACCESS;
                end

                ST_C_ACCESS: begin
                    if (PREADY) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        if (PSLVERR) begin
                            r_err   <= 1'b1;
                            r_state <= ST_IDLE;
                        end else if (w_claim_id == '0) begin
                            if (r_spurious != 8'hFF) begin
                                r_spurious <= r_spurious + 8'd1;
                            end
                            r_state <= ST_IDLE;
                        end else begin
                            r_int_id    <= w_claim_id;
                            r_int_valid <= 1'b1;
                            r_state     <= ST_DISPATCH;
                        end
                    end else begin
                        r_wait <= r_wait + 1'b1;
                        if (w_wait_expired) begin
                            // A claim that never answers is abandoned, never dispatched.
                            r_err     <= 1'b1;
                            r_psel    <= 1'b0;
                            r_penable <= 1'b0;
                            r_state   <= ST_IDLE;
                        end
                    end
                end

                ST_DISPATCH: begin
                    // Handler owns the ID until done; no timeout and no irq/en sampling here.
                    if (int_done) begin
                        r_int_valid <= 1'b0;
                        r_psel      <= 1'b1;
                        r_penable   <= 1'b0;
                        r_pwrite    <= 1'b1;
                        r_pstrb     <= '1;
                        r_pwdata    <= w_wdata;
                        r_state     <= ST_W_SETUP;
                    end
                end

                ST_W_SETUP: begin
                    r_penable <= 1'b1;
                    r_wait    <= '0;
                    r_state   <= ST_W_ACCESS;
                end

                ST_W_ACCESS: begin
                    if (PREADY || w_wait_expired) begin
                        // Error or timeout on the complete is recorded but never retried.
                        if (PREADY ? PSLVERR : 1'b1) begin
                            r_err <= 1'b1;
                        end
                        if (!PREADY) begin
                            r_wait <= r_wait + 1'b1;
                        end
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_pwrite  <= 1'b0;
                        r_pstrb   <= '0;
                        r_pwdata  <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end

                default: begin
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                    r_pwrite    <= 1'b0;
                    r_pstrb     <= '0;
                    r_pwdata    <= '0;
                    r_int_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plic_claim_sequencer.sv
// Scoreboard bench for plic_claim_sequencer: directed stimulus pushes expected
// APB transfers and dispatches; a monitor pops and compares as the DUT shows them.
module tb_plic_claim_sequencer;

    localparam logic [31:0] CLAIM_A0 = 32'h1020_0004;
    localparam logic [31:0] CLAIM_A1 = 32'h1020_1004;
    localparam int K_RD = 0, K_WR = 1, K_DISP = 2;

    logic        clk = 1'b0;
    logic        PRESETn = 1'b0;
    logic        en = 1'b0, irq = 1'b0, int_done = 1'b0;
    logic        PSEL, PENABLE, PWRITE, PREADY = 1'b0, PSLVERR = 1'b0;
    logic [31:0] PADDR, PWDATA, PRDATA = '0;
    logic [3:0]  PSTRB;
    logic        int_valid, err;
    logic [3:0]  int_id;
    logic [7:0]  spurious;

    // Second instance only used to check the per-target address.
    logic        t1_psel, t1_penable, t1_pwrite, t1_int_valid, t1_err;
    logic [31:0] t1_paddr, t1_pwdata;
    logic [3:0]  t1_pstrb, t1_int_id;
    logic [7:0]  t1_spurious;

    int total = 0, bad = 0;

    typedef struct {
        int          kind;
        logic [31:0] data;
        logic [3:0]  strb;
        int          acc;
    } exp_t;
    exp_t sb[$];

    // Slave model controls
    int          slv_wait = 0, slv_cnt = 0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err = 1'b0, slv_hang = 1'b0;

    always #5 clk = ~clk;

    plic_claim_sequencer #(.TARGET(0)) dut (
        .PCLK(clk), .PRESETn(PRESETn), .en(en), .irq(irq),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PSTRB(PSTRB), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .int_valid(int_valid), .int_id(int_id),
        .int_done(int_done), .spurious(spurious), .err(err)
    );

    plic_claim_sequencer #(.TARGET(1)) dut_t1 (
        .PCLK(clk), .PRESETn(PRESETn), .en(1'b0), .irq(1'b0),
        .PSEL(t1_psel), .PENABLE(t1_penable), .PADDR(t1_paddr), .PWRITE(t1_pwrite),
        .PSTRB(t1_pstrb), .PWDATA(t1_pwdata), .PRDATA(32'h0), .PREADY(1'b0),
        .PSLVERR(1'b0), .int_valid(t1_int_valid), .int_id(t1_int_id),
        .int_done(1'b0), .spurious(t1_spurious), .err(t1_err)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] data, input logic [3:0] strb, input int acc);
        exp_t e;
        e.kind = kind; e.data = data; e.strb = strb; e.acc = acc;
        sb.push_back(e);
    endtask

    // APB slave: PREADY after slv_wait wait states unless hung.
    always @(negedge clk) begin
        if (PSEL && PENABLE) begin
            PREADY = !slv_hang && (slv_cnt == slv_wait);
            slv_cnt++;
        end else begin
            PREADY = 1'b0;
            slv_cnt = 0;
        end
        PSLVERR = PREADY && slv_err;
        PRDATA  = slv_rdata;
    end

    // Monitor: pops the scoreboard on each completed transfer or new dispatch.
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_write, stable, prev_valid = 1'b0, chk_gap = 1'b0;
    logic [3:0]  cap_strb;
    int          acc_n = 0;

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!PRESETn) begin
            prev_valid = 1'b0;
            chk_gap    = 1'b0;
        end else begin
            if (chk_gap) begin
                check("idle_gap_psel", PSEL, 1'b0);
                chk_gap = 1'b0;
            end
            if (PSEL && !PENABLE) begin
                cap_addr = PADDR; cap_wdata = PWDATA; cap_write = PWRITE; cap_strb = PSTRB;
                acc_n = 0; stable = 1'b1;
            end
            if (PSEL && PENABLE) begin
                acc_n++;
                if ({PADDR, PWDATA, PWRITE, PSTRB} !== {cap_addr, cap_wdata, cap_write, cap_strb})
                    stable = 1'b0;
                if (PREADY) begin
                    chk_gap = 1'b1;
                    if (sb.size() == 0) begin
                        check("unexpected_apb", 1'b1, 1'b0);
                    end else begin
                        e = sb.pop_front();
                        $display("txn apb write=%0b addr=%h data=%h strb=%h acc=%0d",
                                 PWRITE, PADDR, PWRITE ? PWDATA : PRDATA, PSTRB, acc_n);
                        check("apb_kind", PWRITE ? K_WR : K_RD, e.kind);
                        check("apb_addr", PADDR, CLAIM_A0);
                        check("apb_data", PWRITE ? PWDATA : PRDATA, e.data);
                        check("apb_strb", PSTRB, e.strb);
                        check("apb_acc_cycles", acc_n, e.acc);
                        check("apb_stable", stable, 1'b1);
                    end
                end
            end
            if (int_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_dispatch", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    $display("txn dispatch id=%0d", int_id);
                    check("disp_kind", K_DISP, e.kind);
                    check("disp_id", int_id, e.data[3:0]);
                end
            end
            prev_valid = int_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm, output int n);
        n = 0;
        while (!int_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!int_valid) check(nm, 1'b0, 1'b1);
    endtask

    task automatic pulse_done();
        int_done = 1'b1;
        tick(1);
        int_done = 1'b0;
    endtask

    task automatic pulse_irq();
        irq = 1'b1;
        tick(1);
        irq = 1'b0;
    endtask

    // One full claim / dispatch / complete with the given ID and wait states.
    task automatic service(input logic [3:0] id, input int ws, output int lat);
        slv_wait = ws; slv_rdata = {28'h0, id}; slv_err = 1'b0;
        push(K_RD, {28'h0, id}, 4'h0, ws + 1);
        push(K_DISP, {28'h0, id}, 4'h0, 0);
        push(K_WR, {28'h0, id}, 4'hF, ws + 1);
        irq = 1'b1;
        wait_valid("svc_wait_valid", lat);
        irq = 1'b0;
        pulse_done();
        tick(ws + 8);
    endtask

    task automatic do_reset();
        PRESETn = 1'b0;
        tick(3);
        PRESETn = 1'b1;
        tick(1);
    endtask

    initial begin
        int n, cnt, id0;
        tick(1);
        do_reset();
        PRESETn = 1'b0; tick(1);
        // Reset state and fixed addresses
        check("reset_outputs", {PSEL, PENABLE, PWRITE, PSTRB, PWDATA, int_valid, int_id, spurious, err}, 64'h0);
        check("paddr_t0", PADDR, CLAIM_A0);
        check("paddr_t1", t1_paddr, CLAIM_A1);
        PRESETn = 1'b1;
        en = 1'b1;
        tick(2);

        // Basic zero-wait service, ID 5; int_valid after the 4th edge from irq
        service(4'd5, 0, n);
        check("dispatch_latency", n, 4);
        check("basic_err", err, 1'b0);

        // Three wait states on both accesses
        service(4'd9, 3, n);

        // Spurious claim, then saturation
        slv_wait = 0; slv_rdata = 32'h0;
        push(K_RD, 32'h0, 4'h0, 1);
        pulse_irq(); tick(5);
        check("spurious_first", spurious, 8'd1);
        check("spurious_no_valid", int_valid, 1'b0);
        for (int i = 1; i < 300; i++) begin
            push(K_RD, 32'h0, 4'h0, 1);
            pulse_irq(); tick(5);
            if (i == 254) check("spurious_255", spurious, 8'd255);
        end
        check("spurious_sat", spurious, 8'd255);

        // Upper PRDATA bits ignored: 0xABC0 reads as spurious -> no dispatch
        slv_rdata = 32'h0000_ABC0;
        push(K_RD, 32'h0000_ABC0, 4'h0, 1);
        pulse_irq(); tick(5);
        check("upper_bits_ignored", int_valid, 1'b0);

        // en=0 with irq=1, and int_done while idle: no bus activity
        en = 1'b0; irq = 1'b1; int_done = 1'b1; cnt = 0;
        for (int i = 0; i < 20; i++) begin tick(1); if (PSEL || int_valid) cnt++; end
        check("en0_no_activity", cnt, 0);
        irq = 1'b0; int_done = 1'b0; en = 1'b1;
        tick(2);

        // Handler holds off 50 cycles
        slv_wait = 0; slv_rdata = 32'd6;
        push(K_RD, 32'd6, 4'h0, 1);
        push(K_DISP, 32'd6, 4'h0, 0);
        push(K_WR, 32'd6, 4'hF, 1);
        irq = 1'b1;
        wait_valid("hold_wait_valid", n);
        irq = 1'b0;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin tick(1); if (!int_valid || int_id !== 4'd6 || PSEL) cnt++; end
        check("hold_dispatch_stable", cnt, 0);
        pulse_done();
        tick(8);

        // irq held across two interrupts, IDs 3 then 7
        slv_rdata = 32'd3;
        push(K_RD, 32'd3, 4'h0, 1); push(K_DISP, 32'd3, 4'h0, 0); push(K_WR, 32'd3, 4'hF, 1);
        push(K_RD, 32'd7, 4'h0, 1); push(K_DISP, 32'd7, 4'h0, 0); push(K_WR, 32'd7, 4'hF, 1);
        irq = 1'b1;
        wait_valid("b2b_first_valid", n);
        slv_rdata = 32'd7;
        pulse_done();
        wait_valid("b2b_second_valid", n);
        irq = 1'b0;
        pulse_done();
        tick(8);
        check("b2b_err", err, 1'b0);

        // Reset asserted during the complete's access phase
        slv_wait = 3; slv_rdata = 32'd4;
        push(K_RD, 32'd4, 4'h0, 4); push(K_DISP, 32'd4, 4'h0, 0);
        irq = 1'b1;
        wait_valid("rst_wait_valid", n);
        irq = 1'b0;
        pulse_done();
        n = 0;
        while (!(PSEL && PENABLE && PWRITE) && n < 20) begin tick(1); n++; end
        check("rst_reached_waccess", PSEL && PENABLE && PWRITE, 1'b1);
        PRESETn = 1'b0;
        tick(1);
        check("rst_mid_outputs", {PSEL, PENABLE, PWRITE, PSTRB, PWDATA, int_valid, int_id, spurious, err}, 64'h0);
        PRESETn = 1'b1;
        tick(2);

        // Claim that never gets PREADY: times out after 16 access cycles
        slv_hang = 1'b1;
        pulse_irq();
        n = 0;
        while (!(PSEL && PENABLE) && n < 10) begin tick(1); n++; end
        n = 0;
        while (PSEL && PENABLE && n < 100) begin tick(1); n++; end
        check("timeout_cycles", n, 16);
        check("timeout_err", err, 1'b1);
        check("timeout_psel", PSEL, 1'b0);
        tick(5);
        check("timeout_no_dispatch", int_valid, 1'b0);
        slv_hang = 1'b0;
        do_reset();
        check("err_cleared", err, 1'b0);

        // PSLVERR on the claim: no dispatch
        slv_wait = 0; slv_rdata = 32'd5; slv_err = 1'b1;
        push(K_RD, 32'd5, 4'h0, 1);
        pulse_irq();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin tick(1); if (int_valid) cnt++; end
        check("slverr_no_dispatch", cnt, 0);
        check("slverr_err", err, 1'b1);
        slv_err = 1'b0;

        tick(4);
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
